// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: FSM state encoding, pipeline-control bundle, canned control
//          patterns and the register-match helper used by the hazard logic.
// Ports:   none (package).
package riscv_pipe_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b0, pipe_hold: 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b0, pipe_hold: 1'b1};
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                         id_ex_bubble: 1'b1, pipe_hold: 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                         id_ex_bubble: 1'b1, pipe_hold: 1'b0};
  // Held in reset: nothing advances and both front stages are emptied.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                         id_ex_bubble: 1'b1, pipe_hold: 1'b0};

  // x0 is hard-wired zero, so a write to it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:   clk, rst_n (sync active-low), clr (sync clear, beats inc),
//          inc (count enable), count (current value).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / branch / memory-freeze pipeline hazard controller
// Purpose: drives pipeline write-enables, flush and bubble controls with zero
//          latency, tracks a RUN/MEM_WAIT FSM, counts stalls/flushes/wait
//          cycles and raises a sticky timeout on long memory freezes.
// Ports:   clk, rst_n (sync active-low)
//          if_id_RS1, if_id_RS2, if_id_uses_rs2 : ID-stage source operands
//          id_ex_RD, id_ex_memread              : EX-stage destination / load flag
//          branch_taken, mem_busy, cnt_clr      : events and counter clear
//          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold : controls
//          stall_cnt, flush_cnt, wait_cnt, mem_timeout                : statistics
module hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_RS1,
  input  logic [4:0]       if_id_RS2,
  input  logic             if_id_uses_rs2,
  input  logic [4:0]       id_ex_RD,
  input  logic             id_ex_memread,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_timeout
);

  localparam int RL_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [RL_W-1:0] RL_LIMIT = RL_W'(MAX_WAIT);

  pipe_state_e     state;
  pipe_state_e     next_state;
  pipe_ctrl_t      ctrl;
  logic            lu_hazard;
  logic            stall_evt;
  logic            flush_evt;
  logic [RL_W-1:0] run_len;
  logic [RL_W-1:0] run_len_nxt;

  assign lu_hazard = id_ex_memread &&
                     (reg_match(id_ex_RD, if_id_RS1) ||
                      (if_id_uses_rs2 && reg_match(id_ex_RD, if_id_RS2)));

  // Control decode. The release cycle out of MEM_WAIT decodes exactly like RUN,
  // so a branch held across a freeze only takes effect once, on release.
  always_comb begin
    ctrl       = CTRL_NORMAL;
    next_state = state;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;

    unique case (state)
      RUN:      next_state = mem_busy ? MEM_WAIT : RUN;
      MEM_WAIT: next_state = mem_busy ? MEM_WAIT : RUN;
      default:  next_state = RUN;
    endcase

    if (mem_busy) begin
      ctrl = CTRL_FREEZE;
    end else if (branch_taken) begin
      ctrl      = CTRL_FLUSH;
      flush_evt = 1'b1;
    end else if (lu_hazard) begin
      ctrl      = CTRL_STALL;
      stall_evt = 1'b1;
    end

    if (!rst_n) begin
      ctrl      = CTRL_RESET;
      stall_evt = 1'b0;
      flush_evt = 1'b0;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;

  // Length of the current busy streak including this cycle, clamped at the limit.
  always_comb begin
    run_len_nxt = '0;
    if (mem_busy) begin
      run_len_nxt = (run_len == RL_LIMIT) ? run_len : run_len + 1'b1;
    end
  end

  // The flag is registered on the same edge that the streak reaches the limit,
  // so it is first visible in the cycle after the MAX_WAIT-th busy cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      run_len     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state   <= next_state;
      run_len <= run_len_nxt;
      if (cnt_clr) begin
        mem_timeout <= 1'b0;
      end else if (run_len_nxt == RL_LIMIT) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_evt),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (mem_busy),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 4;
  localparam int SAT      = 3;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  localparam logic [4:0] C_NORM  = 5'b11000;
  localparam logic [4:0] C_FRZ   = 5'b00001;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_RST   = 5'b00110;

  logic             clk;
  logic             rst_n;
  logic [4:0]       if_id_RS1;
  logic [4:0]       if_id_RS2;
  logic             if_id_uses_rs2;
  logic [4:0]       id_ex_RD;
  logic             id_ex_memread;
  logic             branch_taken;
  logic             mem_busy;
  logic             cnt_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_timeout;

  hazard_controller #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_id_RS1      (if_id_RS1),
    .if_id_RS2      (if_id_RS2),
    .if_id_uses_rs2 (if_id_uses_rs2),
    .id_ex_RD       (id_ex_RD),
    .id_ex_memread  (id_ex_memread),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .cnt_clr        (cnt_clr),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .pipe_hold      (pipe_hold),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .wait_cnt       (wait_cnt),
    .mem_timeout    (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic [4:0] rd;
    logic       memread;
    logic       branch;
    logic       busy;
    logic [4:0] ctrl;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  int exp_wait  = 0;
  vec_t vecs[13];

  function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u, input logic [4:0] rd, input logic mr,
                              input logic br, input logic busy, input logic [4:0] ctrl);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.uses_rs2 = u; v.rd = rd;
    v.memread = mr; v.branch = br; v.busy = busy; v.ctrl = ctrl;
    return v;
  endfunction

  function automatic int sat_inc(input int v, input logic inc);
    if (inc && v < SAT) return v + 1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string name, input logic [4:0] exp);
    check(name, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}, {27'd0, exp});
  endtask

  task automatic check_cnts(input string name);
    check({name, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    check({name, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    check({name, ".wait_cnt"},  32'(wait_cnt),  32'(exp_wait));
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                        input logic [4:0] rd, input logic mr, input logic br, input logic busy);
    if_id_RS1 = rs1; if_id_RS2 = rs2; if_id_uses_rs2 = u;
    id_ex_RD = rd; id_ex_memread = mr; branch_taken = br; mem_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_stall = 0; exp_flush = 0; exp_wait = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    vecs[0]  = mk("normal",          5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C_NORM);
    vecs[1]  = mk("lu_rs1",          5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_STALL);
    vecs[2]  = mk("lu_rs2",          5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, C_STALL);
    vecs[3]  = mk("rd0_masked",      5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NORM);
    vecs[4]  = mk("rs2_unused",      5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, C_NORM);
    vecs[5]  = mk("not_load",        5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM);
    vecs[6]  = mk("branch_over_lu",  5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_FLUSH);
    vecs[7]  = mk("busy_over_all",   5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_FRZ);
    vecs[8]  = mk("release_lu",      5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_STALL);
    vecs[9]  = mk("busy_plain",      5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, C_FRZ);
    vecs[10] = mk("release_branch",  5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, C_FLUSH);
    vecs[11] = mk("lu_saturate",     5'd1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, C_STALL);
    vecs[12] = mk("normal_end",      5'd8, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C_NORM);

    // Reset behaviour
    #1;
    check_ctrl("reset_ctrl", C_RST);
    tick();
    tick();
    check_cnts("reset");
    check("reset.mem_timeout", 32'(mem_timeout), 32'd0);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    foreach (vecs[i]) begin
      set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].uses_rs2, vecs[i].rd,
             vecs[i].memread, vecs[i].branch, vecs[i].busy);
      #1;
      check_ctrl({vecs[i].name, ".ctrl"}, vecs[i].ctrl);
      exp_stall = sat_inc(exp_stall, vecs[i].ctrl == C_STALL);
      exp_flush = sat_inc(exp_flush, vecs[i].ctrl == C_FLUSH);
      exp_wait  = sat_inc(exp_wait,  vecs[i].busy);
      tick();
      check_cnts(vecs[i].name);
      check({vecs[i].name, ".mem_timeout"}, 32'(mem_timeout), 32'd0);
    end

    // Clear beats same-cycle increments
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    clear_cnts();
    check_cnts("clr_wins");
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();

    // Freeze with branch held, then single flush on release
    for (int k = 1; k <= 3; k++) begin
      set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
      #1;
      check_ctrl($sformatf("frz_br%0d.ctrl", k), C_FRZ);
      tick();
    end
    exp_wait = 3;
    check_cnts("frz_br");
    set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    #1;
    check_ctrl("frz_br_release.ctrl", C_FLUSH);
    tick();
    exp_flush = 1;
    branch_taken = 1'b0;
    #1;
    check_ctrl("frz_br_after.ctrl", C_NORM);
    tick();
    check_cnts("frz_br_after");
    check("frz_br.mem_timeout", 32'(mem_timeout), 32'd0);

    // Timeout: flag visible after the MAX_WAIT-th consecutive busy cycle
    clear_cnts();
    mem_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("timeout_k%0d", k), 32'(mem_timeout), (k >= MAX_WAIT) ? 32'd1 : 32'd0);
    end
    exp_wait = SAT;
    check_cnts("timeout_wait_sat");
    mem_busy = 1'b0;
    tick();
    tick();
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    clear_cnts();
    check("timeout_cleared", 32'(mem_timeout), 32'd0);
    check_cnts("timeout_cleared");

    // Five load-use stalls saturate a 2-bit counter
    set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    exp_stall = SAT;
    check_cnts("stall_sat");

    // Reset in the middle of a memory wait
    set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_ctrl("rst_in_wait.ctrl", C_RST);
    tick();
    exp_stall = 0; exp_flush = 0; exp_wait = 0;
    check_cnts("rst_in_wait");
    check("rst_in_wait.mem_timeout", 32'(mem_timeout), 32'd0);
    rst_n = 1'b1;
    set_in(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    #1;
    check_ctrl("after_rst.ctrl", C_NORM);
    tick();
    check_cnts("after_rst");
    set_in(5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    check_ctrl("after_rst_lu.ctrl", C_STALL);
    tick();
    exp_stall = 1;
    check_cnts("after_rst_lu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
